// File: rtl/fabric_reset_sequencer.sv
// Fabric reset sequencer: qualifies CCC lock and CoreResetP status, then releases
// three staged fabric reset domains in order and can request a timed FAB_RESET_N pulse.
module fabric_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int SOFT_RST_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES     = 1048576
) (
  input  logic       CLK_BASE,
  input  logic       POWER_ON_RESET_N,
  input  logic       FAB_CCC_LOCK,
  input  logic       INIT_DONE,
  input  logic       MSS_READY,
  input  logic       SOFT_RESET_REQ,
  output logic       FAB_RESET_N,
  output logic [2:0] STAGE_RESET_N,
  output logic       SYS_READY,
  output logic       LOCK_LOST,
  output logic       TIMEOUT_ERR,
  output logic [2:0] STATE
);

  // state       | meaning
  // WAIT_LOCK   | waiting for synced CCC lock
  // LOCK_STABLE | counting consecutive lock-high cycles
  // WAIT_INIT   | waiting for INIT_DONE && MSS_READY, with timeout
  // RELEASE     | releasing stage resets 0,1,2 at STAGE_GAP spacing
  // RUN         | all stages released, SYS_READY high
  // SOFT_RST    | FAB_RESET_N held low for SOFT_RST_CYCLES
  localparam logic [2:0] S_WAIT_LOCK   = 3'd0;
  localparam logic [2:0] S_LOCK_STABLE = 3'd1;
  localparam logic [2:0] S_WAIT_INIT   = 3'd2;
  localparam logic [2:0] S_RELEASE     = 3'd3;
  localparam logic [2:0] S_RUN         = 3'd4;
  localparam logic [2:0] S_SOFT_RST    = 3'd5;

  localparam int REL_END = 3 * STAGE_GAP_CYCLES + 1;
  localparam int MAX_A   = (LOCK_STABLE_CYCLES > TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_B   = (SOFT_RST_CYCLES > REL_END) ? SOFT_RST_CYCLES : REL_END;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LS_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SR_LAST  = CW'(SOFT_RST_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(REL_END);
  localparam logic [CW-1:0] REL0     = CW'(STAGE_GAP_CYCLES);
  localparam logic [CW-1:0] REL1     = CW'(2 * STAGE_GAP_CYCLES);
  localparam logic [CW-1:0] REL2     = CW'(3 * STAGE_GAP_CYCLES);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] init_sync;
  logic [SYNC_STAGES-1:0] mss_sync;
  logic                   rst_n;
  logic                   lock_s;
  logic                   ready_s;
  logic                   soft_d;
  logic                   soft_rise;
  logic [2:0]             state;
  logic [2:0]             nxt;
  logic [CW-1:0]          cnt;
  logic [2:0]             rel_bits;
  logic                   lock_drop;
  logic                   timeout_hit;

  // Reset asserts asynchronously but leaves reset only on a clock edge.
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) rst_sync <= '0;
    else                   rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_n = rst_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK_BASE or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      init_sync <= '0;
      mss_sync  <= '0;
      soft_d    <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], FAB_CCC_LOCK};
      init_sync <= {init_sync[SYNC_STAGES-2:0], INIT_DONE};
      mss_sync  <= {mss_sync[SYNC_STAGES-2:0], MSS_READY};
      soft_d    <= SOFT_RESET_REQ;
    end
  end

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign ready_s   = init_sync[SYNC_STAGES-1] & mss_sync[SYNC_STAGES-1];
  assign soft_rise = SOFT_RESET_REQ & ~soft_d;

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT_LOCK:   if (lock_s) nxt = S_LOCK_STABLE;
      S_LOCK_STABLE: if (!lock_s) nxt = S_WAIT_LOCK;
                     else if (cnt == LS_LAST) nxt = S_WAIT_INIT;
      S_WAIT_INIT:   if (!lock_s) nxt = S_WAIT_LOCK;
                     else if (ready_s) nxt = S_RELEASE;
                     else if (cnt == TO_LAST) nxt = S_SOFT_RST;
      S_RELEASE:     if (!lock_s) nxt = S_WAIT_LOCK;
                     else if (!ready_s) nxt = S_WAIT_INIT;
                     else if (cnt == REL_LAST) nxt = S_RUN;
      S_RUN:         if (!lock_s) nxt = S_WAIT_LOCK;
                     else if (!ready_s) nxt = S_WAIT_INIT;
                     else if (soft_rise) nxt = S_SOFT_RST;
      S_SOFT_RST:    if (cnt == SR_LAST) nxt = S_WAIT_LOCK;
      default:       nxt = S_WAIT_LOCK;
    endcase
  end

  assign rel_bits    = {cnt == REL2, cnt == REL1, cnt == REL0};
  assign lock_drop   = ((state == S_RELEASE) || (state == S_RUN)) && !lock_s;
  assign timeout_hit = (state == S_WAIT_INIT) && (nxt == S_SOFT_RST);

  always_ff @(posedge CLK_BASE or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      FAB_RESET_N   <= 1'b1;
      STAGE_RESET_N <= 3'b000;
      SYS_READY     <= 1'b0;
      LOCK_LOST     <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      state <= nxt;
      // The counter restarts on every state entry; WAIT_LOCK and RUN never use it.
      if ((nxt != state) || (state == S_WAIT_LOCK) || (state == S_RUN)) cnt <= '0;
      else                                                             cnt <= cnt + CW'(1);
      FAB_RESET_N <= (nxt != S_SOFT_RST);
      SYS_READY   <= (nxt == S_RUN);
      if (nxt == S_RUN)                                  STAGE_RESET_N <= 3'b111;
      else if ((nxt == S_RELEASE) && (state == S_RELEASE)) STAGE_RESET_N <= STAGE_RESET_N | rel_bits;
      else                                               STAGE_RESET_N <= 3'b000;
      LOCK_LOST   <= LOCK_LOST | lock_drop;
      TIMEOUT_ERR <= TIMEOUT_ERR | timeout_hit;
    end
  end

  assign STATE = state;

endmodule
